// File: rtl/usb3_phy_seq_pkg.sv
// rtl/usb3_phy_seq_pkg.sv - sequencer state encodings and PIPE PowerDown codes
// Purpose: shared types for usb3_phy_seq; the state values double as the
// seq_state debug output, so the encoding must stay fixed.
package usb3_phy_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_RST     = 3'd1,
        SEQ_STRAP   = 3'd2,
        SEQ_WAIT_ST = 3'd3,
        SEQ_READY   = 3'd4,
        SEQ_PD_WAIT = 3'd5
    } seq_state_e;

    localparam logic [1:0] PD_P0 = 2'b00;
    localparam logic [1:0] PD_P1 = 2'b01;
    localparam logic [1:0] PD_P2 = 2'b10;
    localparam logic [1:0] PD_P3 = 2'b11;

    // PHY is out of reset and sequenced; the pipe and LTSSM may run.
    function automatic logic seq_phy_up(input seq_state_e s);
        return (s == SEQ_READY) || (s == SEQ_PD_WAIT);
    endfunction

endpackage

// File: rtl/usb3_sync2.sv
// rtl/usb3_sync2.sv - two-flop single-bit synchronizer
// Purpose: brings an asynchronous level into the clk domain.
// Ports: clk, reset (sync, active-high), d (async in), q (synced out).
module usb3_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/usb3_phy_seq.sv
// rtl/usb3_phy_seq.sv - PIPE3 PHY bring-up and power-state sequencer
// Purpose: times the PHY reset pulse and strap window, waits for PhyStatus to
// confirm the PHY is up, then serves LTSSM PowerDown requests with a PhyStatus
// handshake and timeout.
// Ports:
//   local_clk, reset         clock and sync active-high reset
//   pll_locked               PLL lock (local_clk domain)
//   vbus_present             PwrPresent (async)
//   phy_phy_status           PhyStatus (async)
//   pd_req_state, pd_req_go  PowerDown request from the LTSSM
//   phy_reset_n, strap_oe, strap_val   PHY reset and strap pins
//   phy_ready, phy_power_down          PHY up flag and PowerDown pins
//   pd_ack, pd_err           1-cycle request result pulses
//   seq_state                FSM state (debug)
module usb3_phy_seq
    import usb3_phy_seq_pkg::*;
#(
    parameter int                 STRAP_W    = 3,
    parameter logic [STRAP_W-1:0] STRAP_VAL  = 3'b110,
    parameter int                 RST_CYCLES = 250,
    parameter int                 STRAP_HOLD = 16,
    parameter int                 PD_TIMEOUT = 4096,
    parameter int                 CNT_W      = 16
) (
    input  logic               local_clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               vbus_present,
    input  logic               phy_phy_status,
    input  logic [1:0]         pd_req_state,
    input  logic               pd_req_go,
    output logic               phy_reset_n,
    output logic               strap_oe,
    output logic [STRAP_W-1:0] strap_val,
    output logic               phy_ready,
    output logic [1:0]         phy_power_down,
    output logic               pd_ack,
    output logic               pd_err,
    output logic [2:0]         seq_state
);

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STRAP_LAST = CNT_W'(STRAP_HOLD - 1);
    localparam logic [CNT_W-1:0] PD_LAST    = CNT_W'(PD_TIMEOUT - 1);

    logic vbus_s, status_s;

    usb3_sync2 u_sync_vbus (
        .clk   (local_clk),
        .reset (reset),
        .d     (vbus_present),
        .q     (vbus_s)
    );

    usb3_sync2 u_sync_status (
        .clk   (local_clk),
        .reset (reset),
        .d     (phy_phy_status),
        .q     (status_s)
    );

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             status_prev_q, status_prev_d;
    logic             phy_reset_n_q, phy_reset_n_d;
    logic             strap_oe_q, strap_oe_d;
    logic             phy_ready_q, phy_ready_d;
    logic [1:0]       pwr_q, pwr_d;
    logic             pd_ack_q, pd_ack_d;
    logic             pd_err_q, pd_err_d;

    logic status_rise, status_fall, supply_ok;

    always_comb begin
        status_prev_d = status_s;
        status_rise   = status_s & ~status_prev_q;
        status_fall   = ~status_s & status_prev_q;
        supply_ok     = pll_locked & vbus_s;

        state_d  = state_q;
        pwr_d    = pwr_q;
        pd_ack_d = 1'b0;
        pd_err_d = 1'b0;

        if (state_q != SEQ_IDLE && !supply_ok) begin
            // Supply loss overrides everything, including a pending ack.
            state_d = SEQ_IDLE;
        end else begin
            case (state_q)
                SEQ_IDLE:    if (supply_ok) state_d = SEQ_RST;
                SEQ_RST:     if (timer_q == RST_LAST) state_d = SEQ_STRAP;
                SEQ_STRAP:   if (timer_q == STRAP_LAST) state_d = SEQ_WAIT_ST;
                SEQ_WAIT_ST: begin
                    // Edge wins over a coincident timeout.
                    if (status_fall) begin
                        state_d = SEQ_READY;
                    end else if (timer_q == PD_LAST) begin
                        pd_err_d = 1'b1;
                        state_d  = SEQ_RST;
                    end
                end
                SEQ_READY: begin
                    if (pd_req_go) begin
                        if (pd_req_state != pwr_q) begin
                            pwr_d   = pd_req_state;
                            state_d = SEQ_PD_WAIT;
                        end else begin
                            pd_ack_d = 1'b1;
                        end
                    end
                end
                SEQ_PD_WAIT: begin
                    if (status_rise) begin
                        pd_ack_d = 1'b1;
                        state_d  = SEQ_READY;
                    end else if (timer_q == PD_LAST) begin
                        pd_err_d = 1'b1;
                        state_d  = SEQ_READY;
                    end
                end
                default: state_d = SEQ_IDLE;
            endcase
            // Requests outside READY are dropped and flagged.
            if (pd_req_go && state_q != SEQ_READY) pd_err_d = 1'b1;
        end

        if (state_d == SEQ_IDLE) pwr_d = PD_P0;

        timer_d = (state_d != state_q) ? '0 : timer_q + CNT_W'(1);

        // Pin outputs are registered from the next state so they line up
        // with seq_state without decode glitches on the PHY pins.
        phy_reset_n_d = !(state_d inside {SEQ_IDLE, SEQ_RST});
        strap_oe_d    = state_d inside {SEQ_IDLE, SEQ_RST, SEQ_STRAP};
        phy_ready_d   = seq_phy_up(state_d);
    end

    always_ff @(posedge local_clk) begin
        if (reset) begin
            state_q       <= SEQ_IDLE;
            timer_q       <= '0;
            status_prev_q <= 1'b0;
            phy_reset_n_q <= 1'b0;
            strap_oe_q    <= 1'b1;
            phy_ready_q   <= 1'b0;
            pwr_q         <= PD_P0;
            pd_ack_q      <= 1'b0;
            pd_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            status_prev_q <= status_prev_d;
            phy_reset_n_q <= phy_reset_n_d;
            strap_oe_q    <= strap_oe_d;
            phy_ready_q   <= phy_ready_d;
            pwr_q         <= pwr_d;
            pd_ack_q      <= pd_ack_d;
            pd_err_q      <= pd_err_d;
        end
    end

    assign phy_reset_n    = phy_reset_n_q;
    assign strap_oe       = strap_oe_q;
    assign strap_val      = STRAP_VAL;
    assign phy_ready      = phy_ready_q;
    assign phy_power_down = pwr_q;
    assign pd_ack         = pd_ack_q;
    assign pd_err         = pd_err_q;
    assign seq_state      = state_q;

endmodule

// File: tb/tb_usb3_phy_seq.sv
// tb/tb_usb3_phy_seq.sv - directed self-checking bench for usb3_phy_seq
module tb_usb3_phy_seq;

    logic       local_clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       vbus_present;
    logic       phy_phy_status;
    logic [1:0] pd_req_state;
    logic       pd_req_go;
    logic       phy_reset_n;
    logic       strap_oe;
    logic [2:0] strap_val;
    logic       phy_ready;
    logic [1:0] phy_power_down;
    logic       pd_ack;
    logic       pd_err;
    logic [2:0] seq_state;

    int checks = 0;
    int errors = 0;

    usb3_phy_seq dut (
        .local_clk      (local_clk),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .vbus_present   (vbus_present),
        .phy_phy_status (phy_phy_status),
        .pd_req_state   (pd_req_state),
        .pd_req_go      (pd_req_go),
        .phy_reset_n    (phy_reset_n),
        .strap_oe       (strap_oe),
        .strap_val      (strap_val),
        .phy_ready      (phy_ready),
        .phy_power_down (phy_power_down),
        .pd_ack         (pd_ack),
        .pd_err         (pd_err),
        .seq_state      (seq_state)
    );

    always #4 local_clk = ~local_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
        int n = 0;
        while (seq_state !== s && n < bound) begin
            tick();
            n++;
        end
        check(tag, seq_state, s);
    endtask

    // Counts cycles spent in state s, starting from a sample already in s.
    task automatic dwell(input logic [2:0] s, input bit inject, output int n);
        n = 1;
        while (n < 5000) begin
            if (inject && n == 5) begin
                pd_req_go    = 1'b1;
                pd_req_state = 2'b10;
            end
            tick();
            if (inject && n == 5) begin
                pd_req_go = 1'b0;
                check("illegal_req_err", pd_err, 1);
            end
            if (seq_state !== s) break;
            n++;
        end
    endtask

    task automatic bring_up(input string tag, input bit inject);
        int n;
        wait_state(3'd1, 10, {tag, "_enter_rst"});
        check({tag, "_rst_n_low"}, phy_reset_n, 0);
        dwell(3'd1, 1'b0, n);
        check({tag, "_rst_cycles"}, n, 250);
        check({tag, "_strap_state"}, seq_state, 3'd2);
        check({tag, "_strap_rst_n"}, phy_reset_n, 1);
        check({tag, "_strap_oe_hi"}, strap_oe, 1);
        dwell(3'd2, inject, n);
        check({tag, "_strap_cycles"}, n, 16);
        check({tag, "_wait_st_state"}, seq_state, 3'd3);
        check({tag, "_wait_st_oe_lo"}, strap_oe, 0);
        tick();
        tick();
        phy_phy_status = 1'b0;
        tick();
        tick();
        check({tag, "_ready_early"}, phy_ready, 0);
        tick();
        check({tag, "_ready_rise"}, phy_ready, 1);
        check({tag, "_ready_state"}, seq_state, 3'd4);
    endtask

    initial begin
        int acks;
        reset          = 1'b1;
        pll_locked     = 1'b1;
        vbus_present   = 1'b1;
        phy_phy_status = 1'b1;
        pd_req_state   = 2'b00;
        pd_req_go      = 1'b0;
        repeat (3) tick();

        check("rst_state", seq_state, 3'd0);
        check("rst_phy_reset_n", phy_reset_n, 0);
        check("rst_strap_oe", strap_oe, 1);
        check("rst_strap_val", strap_val, 3'b110);
        check("rst_phy_ready", phy_ready, 0);
        check("rst_power_down", phy_power_down, 2'b00);
        check("rst_pd_ack", pd_ack, 0);
        check("rst_pd_err", pd_err, 0);

        reset = 1'b0;
        bring_up("bringup", 1'b0);

        // Same-state request: ack next cycle, no state change.
        pd_req_go    = 1'b1;
        pd_req_state = 2'b00;
        tick();
        pd_req_go = 1'b0;
        check("same_ack", pd_ack, 1);
        check("same_state", seq_state, 3'd4);
        check("same_pd", phy_power_down, 2'b00);
        tick();
        check("same_ack_pulse", pd_ack, 0);

        // P2 request completed by a PhyStatus rise.
        pd_req_go    = 1'b1;
        pd_req_state = 2'b10;
        tick();
        pd_req_go = 1'b0;
        check("p2_pd", phy_power_down, 2'b10);
        check("p2_state", seq_state, 3'd5);
        check("p2_ready_held", phy_ready, 1);
        phy_phy_status = 1'b1;
        tick();
        tick();
        check("p2_ack_early", pd_ack, 0);
        tick();
        check("p2_ack", pd_ack, 1);
        check("p2_back_ready", seq_state, 3'd4);
        tick();
        check("p2_ack_pulse", pd_ack, 0);
        phy_phy_status = 1'b0;
        repeat (4) tick();
        check("p2_ready_ignores_edge", seq_state, 3'd4);

        // P3 request with PhyStatus withheld: timeout after 4096 cycles.
        pd_req_go    = 1'b1;
        pd_req_state = 2'b11;
        tick();
        pd_req_go = 1'b0;
        check("to_state", seq_state, 3'd5);
        repeat (4095) tick();
        check("to_not_yet", pd_err, 0);
        check("to_still_wait", seq_state, 3'd5);
        tick();
        check("to_err", pd_err, 1);
        check("to_ready", seq_state, 3'd4);
        check("to_pd_held", phy_power_down, 2'b11);
        check("to_no_ack", pd_ack, 0);
        tick();
        check("to_err_pulse", pd_err, 0);

        // Supply loss mid PD_WAIT with a coincident status rise: no ack.
        pd_req_go    = 1'b1;
        pd_req_state = 2'b01;
        tick();
        pd_req_go = 1'b0;
        check("loss_pd_wait", seq_state, 3'd5);
        vbus_present   = 1'b0;
        phy_phy_status = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pd_ack) acks++;
        end
        check("loss_idle", seq_state, 3'd0);
        check("loss_rst_n", phy_reset_n, 0);
        check("loss_strap_oe", strap_oe, 1);
        check("loss_ready", phy_ready, 0);
        check("loss_pd", phy_power_down, 2'b00);
        repeat (3) begin
            tick();
            if (pd_ack) acks++;
        end
        check("loss_no_ack", acks, 0);
        check("loss_stays_idle", seq_state, 3'd0);

        // Full re-sequence with an illegal request injected during STRAP.
        vbus_present = 1'b1;
        bring_up("reseq", 1'b1);
        check("reseq_pd", phy_power_down, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
